// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and frame constants for the instruction-memory boot loader
package imem_boot_loader_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Frame field widths
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  // The stream is accepted in every state except the two terminal ones
  function automatic logic accepts_bytes(input state_t st);
    return (st != ST_DONE) && (st != ST_ERR);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// rtl/imem_boot_loader_word_packer.sv - packs four stream bytes MSB first into one registered word
module imem_boot_loader_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0]               byte_idx;
  logic [WORD_W-BYTE_W-1:0] shift_q;

  // High while the next accepted byte completes the word
  assign last_byte = (byte_idx == 2'd3);

  // Shift bytes in; on the fourth, publish the word with a one-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx   <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + 2'd1;
        shift_q  <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_data};
        if (last_byte) begin
          word_valid <= 1'b1;
          word_data  <= {shift_q, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a framed program image from a byte stream into instruction memory
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic              rearm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Largest legal word count: the whole memory, written once
  localparam logic [LEN_W:0] IM_DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W:0]     ptr_q;
  logic [BYTE_W-1:0]   chk_q;
  logic                accept;
  logic [LEN_W-1:0]    n_full;
  logic [LEN_W:0]      ptr_inc;
  logic                last_word;
  logic                pack_clear;
  logic                pack_byte;
  logic                last_byte;

  assign rx_ready  = accepts_bytes(state_q);
  assign accept    = rx_valid && rx_ready;
  assign n_full    = {len_q[LEN_W-1:BYTE_W], rx_data};
  assign ptr_inc   = {{(LEN_W-ADDR_W){1'b0}}, ptr_q} + {{LEN_W{1'b0}}, 1'b1};
  assign last_word = (ptr_inc == {1'b0, len_q});

  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign cpu_hold  = (state_q != ST_DONE);

  imem_boot_loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_byte),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_valid (im_we),
    .word_data  (im_wdata)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Frame parsing: next state and packer control
  always_comb begin
    state_d    = state_q;
    pack_clear = (state_q != ST_DATA);
    pack_byte  = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept && rx_data == MAGIC) state_d = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if ({1'b0, n_full} > IM_DEPTH) state_d = ST_ERR;
          else if (n_full == '0)         state_d = ST_CHK;
          else                           state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        pack_byte = accept;
        if (accept && last_byte && last_word) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (accept) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE:   if (rearm) state_d = ST_IDLE;
      ST_ERR:    if (rearm) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Length latch, word pointer, running checksum and write address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      ptr_q   <= '0;
      chk_q   <= '0;
      im_addr <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && rx_data == MAGIC) begin
            chk_q <= '0;
            ptr_q <= '0;
          end
        end
        ST_LEN_HI: if (accept) len_q[LEN_W-1:BYTE_W] <= rx_data;
        ST_LEN_LO: begin
          if (accept) begin
            len_q[BYTE_W-1:0] <= rx_data;
            ptr_q             <= '0;
          end
        end
        ST_DATA: begin
          if (accept) begin
            chk_q <= chk_q ^ rx_data;
            if (last_byte) begin
              im_addr <= ptr_q[ADDR_W-1:0];
              ptr_q   <= ptr_q + {{ADDR_W{1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader with a frame-level reference model
module tb_imem_boot_loader;

  localparam int         ADDR_W = 10;
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [7:0] MAGIC  = 8'hA5;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rearm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rearm    (rearm),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int writes_seen = 0;
  bit rearm_noise = 1'b0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img [0:DEPTH-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every cycle: invariants on the status outputs and every write against the expected list
  always @(negedge clk) begin : compare
    wr_t e;
    if (!reset) begin
      check("hold_is_not_done", cpu_hold, !done);
      check("done_err_exclusive", done && err, 1'b0);
      check("ready_vs_terminal", rx_ready, !(done || err));
      if (im_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", im_addr, im_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", im_addr, e.addr);
          check("wr_data", im_wdata, e.data);
          check("wr_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rearm    = rearm_noise && ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    rearm    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout actual=0 required=1");
    end
    acc = cyc;
    @(posedge clk);
  endtask

  task automatic end_stream();
    @(negedge clk);
    rx_valid = 1'b0;
    rearm    = 1'b0;
  endtask

  // Reference: frame is good iff N fits memory and the checksum equals the XOR of payload bytes
  task automatic send_frame(input int n, input bit bad_chk, input int gap_max, output bit exp_done);
    int         acc;
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] nn;
    nn = n[15:0];
    send_byte(MAGIC, $urandom_range(0, gap_max), acc);
    send_byte(nn[15:8], $urandom_range(0, gap_max), acc);
    send_byte(nn[7:0], $urandom_range(0, gap_max), acc);
    if (n > DEPTH) begin
      exp_done = 1'b0;
      end_stream();
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      for (int bi = 0; bi < 4; bi++) begin
        b = img[w][31 - 8*bi -: 8];
        x = x ^ b;
        send_byte(b, $urandom_range(0, gap_max), acc);
        if (bi == 3) exp_q.push_back('{addr: w, data: img[w], at: acc + 1});
      end
    end
    if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
    send_byte(x, $urandom_range(0, gap_max), acc);
    exp_done = !bad_chk;
    end_stream();
  endtask

  task automatic check_status(input bit exp_done);
    check("status_done", done, exp_done);
    check("status_err", err, !exp_done);
    check("status_hold", cpu_hold, !exp_done);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  task automatic do_rearm();
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm_done", done, 1'b0);
    check("rearm_err", err, 1'b0);
    check("rearm_hold", cpu_hold, 1'b1);
    check("rearm_ready", rx_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rearm    = 1'b0;
    @(negedge clk);
    check("rst_we", im_we, 1'b0);
    check("rst_addr", im_addr, 0);
    check("rst_wdata", im_wdata, 0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_hold", cpu_hold, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc;
    int         w0;
    bit         ed;
    logic [7:0] f1 [8];

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rearm    = 1'b0;
    do_reset();

    // 1: single word, literal image and checksum (24^08^00^05 = 29)
    f1 = '{8'hA5, 8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'h29};
    for (int i = 0; i < 8; i++) begin
      send_byte(f1[i], 0, acc);
      if (i == 6) exp_q.push_back('{addr: 0, data: 32'h24080005, at: acc + 1});
    end
    end_stream();
    check_status(1'b1);
    do_rearm();

    // 2: three words back-to-back, writes four cycles apart
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    w0 = writes_seen;
    send_frame(3, 1'b0, 0, ed);
    check_status(ed);
    check("t2_write_count", writes_seen - w0, 3);
    do_rearm();

    // 3: bad literal checksum; the word is still written
    f1[7] = 8'h12;
    for (int i = 0; i < 8; i++) begin
      send_byte(f1[i], 0, acc);
      if (i == 6) exp_q.push_back('{addr: 0, data: 32'h24080005, at: acc + 1});
    end
    end_stream();
    check_status(1'b0);
    do_rearm();

    // 4: oversize length errors with no writes; empty image succeeds
    w0 = writes_seen;
    send_frame(DEPTH + 1, 1'b0, 0, ed);
    check_status(ed);
    check("t4_err_oversize", err, 1'b1);
    do_rearm();
    send_frame(0, 1'b0, 0, ed);
    check_status(ed);
    check("t4_done_empty", done, 1'b1);
    check("t4_no_writes", writes_seen - w0, 0);
    do_rearm();

    // 5: garbage before a frame is dropped
    send_byte(8'h00, 0, acc);
    send_byte(8'hFF, 0, acc);
    send_byte(8'h3C, 1, acc);
    for (int i = 0; i < 2; i++) img[i] = $urandom;
    send_frame(2, 1'b0, 1, ed);
    check_status(ed);
    do_rearm();

    // 6: reset mid-word aborts; next frame starts from address 0
    send_byte(MAGIC, 0, acc);
    send_byte(8'h00, 0, acc);
    send_byte(8'h02, 0, acc);
    send_byte(8'hDE, 0, acc);
    send_byte(8'hAD, 0, acc);
    w0 = writes_seen;
    do_reset();
    repeat (8) @(negedge clk);
    check("t6_no_spurious_write", writes_seen - w0, 0);
    img[0] = $urandom;
    send_frame(1, 1'b0, 0, ed);
    check_status(ed);
    do_rearm();

    // 7: randomized frames with gaps, stray rearm pulses and some bad checksums
    rearm_noise = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      send_frame(n, ($urandom_range(0, 3) == 0), 3, ed);
      check_status(ed);
      do_rearm();
    end
    rearm_noise = 1'b0;

    // 8: full memory, every address exactly once
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    w0 = writes_seen;
    send_frame(DEPTH, 1'b0, 0, ed);
    check_status(ed);
    check("t8_full_count", writes_seen - w0, DEPTH);
    do_rearm();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
